// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: data width, buffer depth and the
// header byte field layout used by the output FIFOs.
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 16;

    localparam int LEN_MSB      = 7;
    localparam int LEN_LSB      = 2;
    localparam int ADDR_MSB     = 1;
    localparam int ADDR_LSB     = 0;

    localparam int HDR_FLAG_BIT = DATA_W;

    // Packet counter is wide enough for the largest payload length plus parity.
    localparam int CNT_W        = 7;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t pkt_remaining(input logic [DATA_W-1:0] hdr);
        return cnt_t'(hdr[LEN_MSB:LEN_LSB]) + cnt_t'(1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: stores header/payload/parity
// bytes with a header tag and tracks remaining packet length on the read side.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = DATA_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             lfd_q;
    cnt_t             count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH:0]   mem [DEPTH];

    logic             do_wr;
    logic             do_rd;
    logic [WIDTH:0]   rd_entry;

    // Extra wrap bit distinguishes full from empty when the low bits match.
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign do_wr    = write_enb && !full && !soft_reset;
    assign do_rd    = read_enb && !empty && !soft_reset;
    assign rd_entry = mem[rd_ptr_q[PTR_W-1:0]];

    assign data_out = dout_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (soft_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = rd_entry[WIDTH-1:0];
                if (rd_entry[WIDTH]) begin
                    count_d = pkt_remaining(rd_entry[WIDTH-1:0]);
                end else if (count_q != '0) begin
                    count_d = count_q - cnt_t'(1);
                end
            end else if (count_q == '0) begin
                // Packet fully drained: the output bus returns to zero.
                dout_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lfd_q    <= 1'b0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lfd_q    <= soft_reset ? 1'b0 : lfd_state;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Header byte lags lfd_state by one cycle, so the delayed flag tags it.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the storage array is cleared on the hard reset only; the
        // soft flush just rewinds pointers and leaves stale contents behind.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= {lfd_q, data_in};
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: table-driven single packet plus
// scoreboarded corner-case sequences (full, simultaneous r/w, flush, wrap).
module tb_router_fifo;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    always #5 clock = ~clock;

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue of {header flag, byte} entries.
    logic [8:0] sb[$];
    logic [7:0] m_dout = 8'h00;
    logic [6:0] m_cnt  = 7'd0;
    logic       m_lfd  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_clear();
        sb.delete();
        m_dout = 8'h00;
        m_cnt  = 7'd0;
        m_lfd  = 1'b0;
    endtask

    // Drive one cycle, update the model with pre-edge state, compare after the edge.
    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic [7:0] din, input logic srst, input string tag);
        logic       m_full, m_empty;
        logic [8:0] e;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = srst;
        @(posedge clock);
        #1;
        if (srst) begin
            model_clear();
        end else begin
            m_full  = (sb.size() == 16);
            m_empty = (sb.size() == 0);
            if (re && !m_empty) begin
                e      = sb.pop_front();
                m_dout = e[7:0];
                if (e[8]) m_cnt = 7'(e[7:2]) + 7'd1;
                else if (m_cnt != 0) m_cnt = m_cnt - 7'd1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (we && !m_full) sb.push_back({m_lfd, din});
            m_lfd = lfd;
        end
        check({tag, "/full"},  32'(full),         32'(sb.size() == 16));
        check({tag, "/empty"}, 32'(empty),        32'(sb.size() == 0));
        check({tag, "/dout"},  32'(data_out),     32'(m_dout));
        check({tag, "/count"}, 32'(dut.count_q),  32'(m_cnt));
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        soft_reset = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic       re;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_empty;
        logic [6:0] exp_cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 7'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h0E, 8'h00, 1'b0, 7'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hA1, 8'h00, 1'b0, 7'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'hB2, 8'h00, 1'b0, 7'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b0, 7'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'hDE, 8'h00, 1'b0, 7'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0E, 1'b0, 7'd4};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA1, 1'b0, 7'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hB2, 1'b0, 7'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b0, 7'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hDE, 1'b1, 7'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'd0};

        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;

        // Reset
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst/full",  32'(full),     32'd0);
        check("rst/empty", 32'(empty),    32'd1);
        check("rst/dout",  32'(data_out), 32'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "rst_rd0");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "rst_rd1");
        check("rst/rd_ptr", 32'(dut.rd_ptr_q), 32'd0);

        // Single packet, table-driven
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din, 1'b0, $sformatf("pkt%0d", i));
            check($sformatf("pkt%0d/tbl_dout", i),  32'(data_out),    32'(vecs[i].exp_dout));
            check($sformatf("pkt%0d/tbl_empty", i), 32'(empty),       32'(vecs[i].exp_empty));
            check($sformatf("pkt%0d/tbl_cnt", i),   32'(dut.count_q), 32'(vecs[i].exp_cnt));
        end

        // Full boundary: 16 writes, 17th (0x55) dropped, 16 reads never see it
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 1'b0, "fill");
        check("full/after16", 32'(full), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, "wr17");
        check("full/held", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "drain");
            check("drain/no55", 32'(data_out == 8'h55), 32'd0);
            check("drain/val",  32'(data_out),          32'(8'h10 + i));
        end
        check("drain/empty", 32'(empty), 32'd1);

        // Simultaneous read+write at occupancy 16
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i), 1'b0, "fill2");
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, "rw_full");
        check("rw_full/full", 32'(full), 32'd0);
        check("rw_full/occ",  32'(5'(dut.wr_ptr_q - dut.rd_ptr_q)), 32'd15);
        check("rw_full/dout", 32'(data_out), 32'h60);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "drain2");
            check("drain2/no77", 32'(data_out == 8'h77), 32'd0);
        end

        // Simultaneous read+write at occupancy 0
        step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0, "rw_empty");
        check("rw_empty/empty", 32'(empty),    32'd0);
        check("rw_empty/dout",  32'(data_out), 32'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "rw_empty_rd");
        check("rw_empty_rd/dout", 32'(data_out), 32'h33);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "idle");

        // Soft reset mid-packet, coincident with a write
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "sr_lfd");
        step(1'b1, 1'b0, 1'b0, 8'h14, 1'b0, "sr_hdr");
        step(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, "sr_p0");
        step(1'b1, 1'b0, 1'b0, 8'hBB, 1'b0, "sr_p1");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "sr_rd");
        check("sr_rd/cnt", 32'(dut.count_q), 32'd6);
        step(1'b1, 1'b0, 1'b0, 8'h99, 1'b1, "sr_flush");
        check("sr/empty", 32'(empty),       32'd1);
        check("sr/dout",  32'(data_out),    32'h00);
        check("sr/cnt",   32'(dut.count_q), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "sr_after");
        check("sr_after/empty", 32'(empty), 32'd1);

        // Wrap-around at occupancy 5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0, "wrap_pre");
        for (int i = 0; i < 35; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, "wrap");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "wrap_post");
        check("wrap/empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-packet, observed before any clock edge
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "ar_lfd");
        step(1'b1, 1'b0, 1'b0, 8'h08, 1'b0, "ar_hdr");
        step(1'b1, 1'b0, 1'b0, 8'hC1, 1'b0, "ar_p0");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "ar_rd");
        #1 reset = 1'b1;
        #1;
        model_clear();
        check("ar/empty", 32'(empty),       32'd1);
        check("ar/full",  32'(full),        32'd0);
        check("ar/dout",  32'(data_out),    32'h00);
        check("ar/cnt",   32'(dut.count_q), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "ar_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
